// File: rtl/vip_chimera_uart_rx.sv
// -----------------------------------------------------------------------------
// vip_chimera_uart_rx
// Simulation-side 8N1 UART receiver for the chimera VIP console logger. It
// oversamples the SoC uart_tx line at a fixed ClkPerBit ratio, buffers decoded
// bytes in a small FIFO and flags framing errors and FIFO overflow.
//
// Ports:
//   clk_i        single clock domain
//   rst_ni       asynchronous active-low reset
//   uart_rx_i    serial line (idle high), resynchronised by two flops
//   clear_i      synchronous clear of the sticky overflow_o
//   data_o       byte at the FIFO head (0 while the FIFO is empty)
//   valid_o      FIFO non-empty
//   ready_i      consumer accept
//   frame_err_o  one-cycle pulse when a stop bit samples 0
//   overflow_o   sticky: a good byte was dropped because the FIFO was full
//   busy_o       receive FSM is not in IDLE
//
// Handshake: a byte is transferred in every cycle where valid_o && ready_i is
// high at the rising clock edge; data_o holds steady while valid_o && !ready_i.
// -----------------------------------------------------------------------------
module vip_chimera_uart_rx #(
  parameter int unsigned ClkPerBit = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  input  logic       clear_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(ClkPerBit);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClkPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(ClkPerBit - 1);
  localparam logic [PtrW:0]   Depth  = (PtrW + 1)'(FifoDepth);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  // ---------------- input synchronizer and edge detect ----------------
  logic       rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0] sync_fill_q;
  logic       seen_high_q;

  // sync_fill_q marks when rx_s_q carries a real sampled value rather than its
  // reset value; seen_high_q then arms start detection only once the line has
  // genuinely been observed high, so a line held low through reset is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      sync_fill_q <= 2'b00;
      seen_high_q <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx_i;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      seen_high_q <= seen_high_q | (sync_fill_q[1] & rx_s_q);
    end
  end

  // ---------------- receive FSM ----------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (seen_high_q && rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        // Mid start bit: a line back high means a glitch, not a frame.
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off through a break so a long low does not look like a start.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------- byte FIFO ----------------
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            overflow_q;
  logic            full, pop, push_ok, ovf_set;

  assign full    = (count_q == Depth);
  assign pop     = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (PtrW + 1)'(1);
      // A new overflow beats a simultaneous clear.
      if (ovf_set)      overflow_q <= 1'b1;
      else if (clear_i) overflow_q <= 1'b0;
    end
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_vip_chimera_uart_rx.sv
module tb_vip_chimera_uart_rx;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       clear;
  logic       ready;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o, busy_o;

  always #5 clk = ~clk;

  vip_chimera_uart_rx #(.ClkPerBit(CPB), .FifoDepth(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .uart_rx_i   (uart_rx),
    .clear_i     (clear),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;  // bit times the line stays low after the frame
    int         exp_err;   // frame_err_o pulses expected
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drives nbits of an 8N1 frame LSB-first; call on a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && valid_o && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=0x%0h required=no_byte", data_o);
        end else begin
          check("data_pop", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
        end
      end
      if (frame_err_o) err_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0, b0;
    vecs[0] = '{8'h55, 1'b1, 0, 0};
    vecs[1] = '{8'hA3, 1'b0, 3, 1};
    vecs[2] = '{8'h41, 1'b1, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 0, 0};
    vecs[5] = '{8'($urandom_range(0, 255)), 1'b1, 0, 0};

    rst_n = 1'b0; uart_rx = 1'b1; clear = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_data", {24'h0, data_o}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err_o}, 32'h0);
    check("rst_overflow", {31'h0, overflow_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Frames from the table, including a bad stop bit followed by a break.
    for (int v = 0; v < 6; v++) begin
      e0 = err_cnt;
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, 10);
      if (vecs[v].hold_low > 0) begin
        repeat (vecs[v].hold_low * CPB) @(negedge clk);
        check("wait_idle_busy", {31'h0, busy_o}, 32'h1);
        uart_rx = 1'b1;
      end
      repeat (2 * CPB) @(negedge clk);
      check("vec_frame_err", err_cnt - e0, vecs[v].exp_err);
      check("vec_drained", exp_q.size(), 32'h0);
      check("vec_idle", {31'h0, busy_o}, 32'h0);
      check("vec_overflow", {31'h0, overflow_o}, 32'h0);
    end

    // Short start-bit glitch.
    b0 = busy_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_window", {31'h0, (busy_cnt - b0 > 0) && (busy_cnt - b0 <= 10)}, 32'h1);
    check("glitch_no_valid", {31'h0, valid_o}, 32'h0);

    // Overflow with consumer stalled, then drain and clear.
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 10);
    end
    repeat (CPB) @(negedge clk);
    check("ovf_set", {31'h0, overflow_o}, 32'h1);
    check("ovf_head", {24'h0, data_o}, 32'h01);
    repeat (5) @(negedge clk);
    check("ovf_head_stable", {24'h0, data_o}, 32'h01);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drained", exp_q.size(), 32'h0);
    check("ovf_empty", {31'h0, valid_o}, 32'h0);
    check("ovf_sticky", {31'h0, overflow_o}, 32'h1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("ovf_cleared", {31'h0, overflow_o}, 32'h0);

    // Full FIFO with a pop in exactly the push cycle of the fifth byte.
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 10);
    end
    exp_q.push_back(8'h05);
    fork
      send_frame(8'h05, 1'b1, 10);
      begin
        repeat (CPB * 9 + CPB - 6) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (CPB) @(negedge clk);
    check("full_pop_no_ovf", {31'h0, overflow_o}, 32'h0);
    check("full_pop_remaining", exp_q.size(), 32'h4);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    check("full_pop_drained", exp_q.size(), 32'h0);

    // Reset during bit 4 of a frame.
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 10);
    check("pre_rst_valid", {31'h0, valid_o}, 32'h1);
    send_frame(8'h33, 1'b1, 5);
    uart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, valid_o}, 32'h0);
    check("arst_data", {24'h0, data_o}, 32'h0);
    check("arst_busy", {31'h0, busy_o}, 32'h0);
    check("arst_frame_err", {31'h0, frame_err_o}, 32'h0);
    check("arst_overflow", {31'h0, overflow_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ready = 1'b1;
    e0 = err_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 10);
    repeat (CPB) @(negedge clk);
    check("post_rst_drained", exp_q.size(), 32'h0);
    check("post_rst_frame_err", err_cnt - e0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
